// File: rtl/btn_rate_select.sv
// Button front end: 2-flop sync, 4-state debounce, press/release/long-press strobes, rate index.
// Latency: press/release strobe one cycle after edge DEBOUNCE_CYCLES+3; long strobe LONG_PRESS_CYCLES after press.
// Backpressure: none; strobes are single-cycle and must be consumed when high. Long press gated by BTN_LONG_PRESS_EN.
module btn_rate_select #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int NUM_RATES         = 4,
    parameter int RATE_W            = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_in,
    output logic              btn_level,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_pulse,
    output logic [RATE_W-1:0] rate_sel
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]     DMAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]     DONE = DW'(1);
    localparam logic [RATE_W-1:0] RMAX = RATE_W'(NUM_RATES - 1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ARM_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] ARM_RELEASE = 2'd3;

    logic          s1;
    logic          s2;
    logic [1:0]    state;
    logic [DW-1:0] dcnt;
    logic          accept_press;
    logic          accept_release;
    logic [RATE_W-1:0] rate_inc;

    assign accept_press   = (state == ARM_PRESS)   &&  s2 && (dcnt == DMAX);
    assign accept_release = (state == ARM_RELEASE) && !s2 && (dcnt == DMAX);
    assign rate_inc       = (rate_sel == RMAX) ? '0 : rate_sel + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= IDLE;
            dcnt          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= btn_in;
            s2            <= s1;
            press_pulse   <= accept_press;
            release_pulse <= accept_release;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= ARM_PRESS;
                        dcnt  <= DONE;
                    end
                end
                ARM_PRESS: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (dcnt == DMAX) begin
                        state     <= PRESSED;
                        btn_level <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= ARM_RELEASE;
                        dcnt  <= DONE;
                    end
                end
                ARM_RELEASE: begin
                    if (s2) begin
                        state <= PRESSED;
                    end else if (dcnt == DMAX) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HLAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hcnt;
    logic          long_done;
    logic          holding;
    logic          long_hit;

    assign holding  = (state == PRESSED) || (state == ARM_RELEASE);
    // A release landing on the same edge wins: that press counts as short.
    assign long_hit = holding && !long_done && (hcnt == HLAST) && !accept_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt       <= '0;
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
            rate_sel   <= '0;
        end else begin
            long_pulse <= long_hit;
            if (accept_press) begin
                hcnt      <= '0;
                long_done <= 1'b0;
            end else if (holding && !long_done) begin
                hcnt <= hcnt + 1'b1;
                if (long_hit) long_done <= 1'b1;
            end
            if (long_hit)
                rate_sel <= '0;
            else if (accept_release && !long_done)
                rate_sel <= rate_inc;
        end
    end
`else
    assign long_pulse = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rate_sel <= '0;
        else if (accept_release)
            rate_sel <= rate_inc;
    end
`endif

endmodule

// File: doc/btn_rate_select.md
# btn_rate_select

Debounced push-button front end for the Cmod A7 LED blinker, sitting directly upstream of it. It synchronises a raw, bouncing button input and filters it with a 4-state debounce FSM. It emits single-cycle press, release and long-press events. Short presses step a blink-rate index, and a long press returns it to 0. The downstream blinker uses `rate_sel` to choose its toggle terminal count.

## Interface
- `DEBOUNCE_CYCLES`, default 120000: consecutive stable cycles required to accept a level change (10 ms at 12 MHz). Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 12000000: hold time, measured from `press_pulse`, that qualifies as a long press (1 s). Must be ≥ 2.
- `NUM_RATES`, default 4: number of rate indices. Range 2..2^`RATE_W`.
- `RATE_W`, default 2: width of `rate_sel`.
- `clk` in 1: system clock, 12 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `btn_in` in 1: raw button, asynchronous to `clk`. High = pressed.
- `btn_level` out 1: debounced button level.
- `press_pulse` out 1: one-cycle strobe on an accepted press.
- `release_pulse` out 1: one-cycle strobe on an accepted release.
- `long_pulse` out 1: one-cycle strobe when a held press reaches `LONG_PRESS_CYCLES`.
- `rate_sel` out `RATE_W`: current blink-rate index.

## Operation
- **Synchroniser:** two flops, `btn_in` → s1 → s2. Only s2 is used downstream.
- **FSM states:** IDLE, ARM_PRESS, PRESSED, ARM_RELEASE.
- **Debounce counter:** `dcnt`, width sized for `DEBOUNCE_CYCLES`.
- **IDLE:**
  - s2=1 → ARM_PRESS, `dcnt`=1.
  - Otherwise stay.
- **ARM_PRESS:**
  - s2=0 → IDLE (a bounce; no event).
  - s2=1 and `dcnt`==`DEBOUNCE_CYCLES` → PRESSED. Same edge: `press_pulse`=1, `btn_level`=1, `hcnt`=0, `long_done`=0.
  - Otherwise `dcnt`+1.
- **PRESSED:**
  - s2=0 → ARM_RELEASE, `dcnt`=1.
- **ARM_RELEASE:**
  - s2=1 → PRESSED (a bounce; no event; `hcnt` not cleared).
  - s2=0 and `dcnt`==`DEBOUNCE_CYCLES` → IDLE. Same edge: `release_pulse`=1, `btn_level`=0.
  - Otherwise `dcnt`+1.
- **Hold counter `hcnt`:**
  - Increments every edge in PRESSED and ARM_RELEASE while `long_done`=0.
  - When `hcnt` reaches `LONG_PRESS_CYCLES`-1 and increments: `long_pulse`=1 for one cycle, `long_done`=1, `rate_sel`=0. `hcnt` then holds.
- **Rate update on the release edge:**
  - `long_done`=0 → `rate_sel` = (`rate_sel`==`NUM_RATES`-1) ? 0 : `rate_sel`+1.
  - `long_done`=1 → `rate_sel` unchanged.
- At most one of `press_pulse` / `release_pulse` / `long_pulse` is high in any cycle.

## Timing
- **Reset values:** s1, s2, `btn_level`, all pulses, `rate_sel`, `dcnt`, `hcnt` and `long_done` are 0; state is IDLE. Reset takes effect immediately.
- **Reset mid-operation:** all of the above are cleared. No pulse is emitted on reset assertion or deassertion.
- **Press latency:** with `btn_in` high and stable from before clock edge 1, `press_pulse` is high in the cycle following edge `DEBOUNCE_CYCLES`+3. Release latency is identical.
- **Long-press latency:** `long_pulse` follows `press_pulse` by exactly `LONG_PRESS_CYCLES` cycles, provided the FSM stays in PRESSED/ARM_RELEASE.
- **Release before long press:** a release completing before `long_pulse` counts as a short press, even if bounces occurred.
- **Wrap-around:** `rate_sel`=`NUM_RATES`-1 plus a short press gives 0.
- **Pulse width:** every pulse is registered and exactly one cycle wide.

## Configuration
- `BTN_LONG_PRESS_EN` defined: `hcnt`, `long_done` and the long-press behaviour are as above.
- `BTN_LONG_PRESS_EN` not defined:
  - `hcnt` and `long_done` are not implemented.
  - `long_pulse` is tied to 0.
  - Every accepted release increments `rate_sel` with wrap.
  - `LONG_PRESS_CYCLES` is ignored.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, `NUM_RATES`=4, macro defined unless stated.
- **Reset:** assert `rst` for 3 cycles with `btn_in`=1 → all outputs 0 during reset. `press_pulse` fires 7 edges after deassertion, and `rate_sel` stays 0.
- **Bounce rejection:** `btn_in` toggles every 2 cycles for 30 cycles, then stays low → no pulses; `btn_level`=0; `rate_sel`=0.
- **Clean short press:** hold high for 10 cycles, then low → `press_pulse` at edge 7, `release_pulse` 7 edges after the fall; `rate_sel` 0→1.
- **Wrap:** 4 short presses from reset → `rate_sel` goes 1, 2, 3, 0.
- **Long press:** preload `rate_sel`=2, hold 40 cycles → `long_pulse` 20 cycles after `press_pulse`, `rate_sel`=0 on that edge, and still 0 after `release_pulse`.
- **Macro undefined:** same 40-cycle hold from `rate_sel`=2 → `long_pulse` never asserts; `rate_sel`=3 after release.
